// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter
//   Shares one framebuffer write port among NUM_REQ pixel generators.
//   Each generator offers words on an rts/rtr handshake. One generator is
//   granted at a time, and grants rotate round-robin. A grant is released
//   when its requester drops rts, or after MAX_BURST accepted words. The
//   winning word passes through one registered stage to memory.
//
//   Optional build macro:
//     FBA_FIXED_PRIO_EN  The IDLE pick is the lowest asserted index, so
//                        requester 0 has the highest priority. The
//                        MAX_BURST release still applies.
//
//   Ports:
//     clk       in   1               clock, all logic on posedge
//     rst       in   1               asynchronous active-high reset
//     req_addr  in   NUM_REQ*ADDR_W  requester word addresses, slice i = requester i
//     req_data  in   NUM_REQ*DATA_W  requester write data
//     req_wben  in   NUM_REQ*WBEN_W  requester byte write enables
//     req_rts   in   NUM_REQ         requester has a word to send
//     req_rtr   out  NUM_REQ         arbiter accepts the requester's word
//     arb_gnt   out  NUM_REQ         one-hot current grant, 0 while IDLE
//     mem_addr  out  ADDR_W          registered address to the framebuffer
//     mem_data  out  DATA_W          registered data
//     mem_wben  out  WBEN_W          registered byte enables
//     mem_rts   out  1               output word valid
//     mem_rtr   in   1               framebuffer accepts the word
module fb_write_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]     req_data,
  input  logic [NUM_REQ*(DATA_W/8)-1:0] req_wben,
  input  logic [NUM_REQ-1:0]            req_rts,
  output logic [NUM_REQ-1:0]            req_rtr,
  output logic [NUM_REQ-1:0]            arb_gnt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_data,
  output logic [(DATA_W/8)-1:0]         mem_wben,
  output logic                          mem_rts,
  input  logic                          mem_rtr
);

  localparam int WBEN_W = DATA_W / 8;
  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_BURST) + 1;

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]  maddr_q, maddr_d;
  logic [DATA_W-1:0]  mdata_q, mdata_d;
  logic [WBEN_W-1:0]  mwben_q, mwben_d;
  logic               mrts_q, mrts_d;

  logic               out_ready;
  logic               xfc;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  int                 cand;

  // last_q always holds the index of the current grant while in GRANT,
  // so it doubles as the mux select for the winning slice.
  assign out_ready = !mrts_q || mem_rtr;
  assign req_rtr   = (state_q == S_GRANT) ? (gnt_q & {NUM_REQ{out_ready}}) : '0;
  assign xfc       = |(req_rts & req_rtr);
  assign arb_gnt   = gnt_q;
  assign mem_addr  = maddr_q;
  assign mem_data  = mdata_q;
  assign mem_wben  = mwben_q;
  assign mem_rts   = mrts_q;

  // Arbitration pick for the IDLE cycle.
  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
`ifdef FBA_FIXED_PRIO_EN
    // Scan downwards so the lowest asserted index is written last.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rts[k]) begin
        pick_idx   = IDX_W'(k);
        pick_found = 1'b1;
      end
    end
`else
    // Search starts just after the previous winner and wraps around.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!pick_found && req_rts[cand]) begin
        pick_idx   = IDX_W'(cand);
        pick_found = 1'b1;
      end
    end
`endif
  end

  // Grant FSM next state.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          gnt_d   = NUM_REQ'(1) << pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        if (xfc) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // The burst ends on the transfer that completes MAX_BURST words.
        if (!req_rts[last_q] || (xfc && (cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          gnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // Output register next state: load on transfer, drain on mem_rtr, else hold.
  always_comb begin
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    mwben_d = mwben_q;
    mrts_d  = mrts_q;
    if (xfc) begin
      maddr_d = req_addr[int'(last_q)*ADDR_W +: ADDR_W];
      mdata_d = req_data[int'(last_q)*DATA_W +: DATA_W];
      mwben_d = req_wben[int'(last_q)*WBEN_W +: WBEN_W];
      mrts_d  = 1'b1;
    end else if (mem_rtr) begin
      mrts_d  = 1'b0;
    end
  end

  // Stage boundary: arbitration state and output word register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      cnt_q   <= '0;
      maddr_q <= '0;
      mdata_q <= '0;
      mwben_q <= '0;
      mrts_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
      mwben_q <= mwben_d;
      mrts_q  <= mrts_d;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
module tb_fb_write_arbiter;

  localparam logic [31:0] D0 = 32'h000000FF;
  localparam logic [31:0] D1 = 32'hAAAA5555;
  localparam logic [3:0]  W0 = 4'h1;
  localparam logic [3:0]  W1 = 4'hF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] req_addr = '0;
  logic [63:0] req_data = '0;
  logic [7:0]  req_wben = '0;
  logic [1:0]  req_rts = '0;
  logic [1:0]  req_rtr;
  logic [1:0]  arb_gnt;
  logic [15:0] mem_addr;
  logic [31:0] mem_data;
  logic [3:0]  mem_wben;
  logic        mem_rts;
  logic        mem_rtr = 1'b1;

  int n_vec = 0;
  int n_bad = 0;

  fb_write_arbiter #(.NUM_REQ(2), .ADDR_W(16), .DATA_W(32), .MAX_BURST(16)) dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_data(req_data), .req_wben(req_wben),
    .req_rts(req_rts), .req_rtr(req_rtr), .arb_gnt(arb_gnt),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wben(mem_wben),
    .mem_rts(mem_rts), .mem_rtr(mem_rtr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [1:0]  rts;
    logic        mrtr;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [1:0]  egnt;
    logic [1:0]  ertr;
    logic        emrts;
    logic [15:0] ema;
    logic [31:0] emd;
    logic [3:0]  emw;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [1:0] rts, logic mrtr, logic [15:0] a0,
                              logic [15:0] a1, logic [1:0] egnt, logic [1:0] ertr,
                              logic emrts, logic [15:0] ema, logic [31:0] emd, logic [3:0] emw);
    vec_t v;
    v.rst = r; v.rts = rts; v.mrtr = mrtr; v.a0 = a0; v.a1 = a1;
    v.egnt = egnt; v.ertr = ertr; v.emrts = emrts; v.ema = ema; v.emd = emd; v.emw = emw;
    return v;
  endfunction

  // Requester models for the hand-written sequences.
  logic [1:0]  m_rts = '0;
  logic        m_mrtr = 1'b1;
  int          cnt[2];
  logic [51:0] sb[$];
  logic [1:0]  gnt_log[$];
  logic        xfc_log[$];
  logic [51:0] held;
  bit          have_held = 0;

  function automatic logic [51:0] word_of(int i, int c);
    logic [15:0] a;
    logic [31:0] d;
    logic [3:0]  w;
    a = ((i == 0) ? 16'h0000 : 16'h1000) + 16'(c);
    d = {8'(8'hA0 + i), 8'h00, 16'(c)};
    w = (i == 0) ? 4'h3 : 4'hC;
    return {a, d, w};
  endfunction

  task automatic cycle();
    logic [51:0] w;
    logic [1:0]  x;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      w = word_of(i, cnt[i]);
      req_addr[i*16 +: 16] = w[51:36];
      req_data[i*32 +: 32] = w[35:4];
      req_wben[i*4 +: 4]   = w[3:0];
    end
    req_rts = m_rts;
    mem_rtr = m_mrtr;
    #1;
    x = req_rts & req_rtr;
    gnt_log.push_back(arb_gnt);
    xfc_log.push_back(|x);
    chk("rtr_only_granted", 64'(req_rtr & ~arb_gnt), 64'd0);
    if (!m_mrtr && mem_rts) begin
      if (!have_held) begin
        held = {mem_addr, mem_data, mem_wben};
        have_held = 1;
      end else begin
        chk("stall_hold", {mem_addr, mem_data, mem_wben}, held);
      end
      chk("stall_rtr", 64'(req_rtr), 64'd0);
    end else begin
      have_held = 0;
    end
    if (mem_rts && mem_rtr) begin
      if (sb.size() == 0) chk("sb_extra_word", {mem_addr, mem_data, mem_wben}, 64'hDEAD);
      else chk("sb_word", {mem_addr, mem_data, mem_wben}, sb.pop_front());
    end
    for (int i = 0; i < 2; i++) begin
      if (x[i]) begin
        sb.push_back(word_of(i, cnt[i]));
        cnt[i]++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_rts = '0;
    mem_rtr = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt[0] = 0; cnt[1] = 0;
    sb.delete();
    gnt_log.delete();
    xfc_log.delete();
    have_held = 0;
  endtask

  task automatic drain();
    m_rts = '0;
    m_mrtr = 1'b1;
    for (int k = 0; k < 6 && sb.size() > 0; k++) cycle();
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Splits the grant log into episodes (grant, words, idle cycles before it).
  task automatic check_episodes(input string nm, input int n,
                                input logic [1:0] g0, input logic [1:0] g1, input logic [1:0] g2);
    logic [1:0] gs[$];
    int         words[$];
    int         gaps[$];
    logic [1:0] prev;
    logic [1:0] expg;
    int         zr;
    prev = '0;
    zr = 0;
    for (int t = 0; t < gnt_log.size(); t++) begin
      if (gnt_log[t] != 2'b00) begin
        if (gnt_log[t] != prev) begin
          gs.push_back(gnt_log[t]);
          words.push_back(0);
          gaps.push_back(zr);
        end
        zr = 0;
        if (xfc_log[t]) words[words.size()-1]++;
      end else begin
        zr++;
      end
      prev = gnt_log[t];
    end
    for (int e = 0; e < n; e++) begin
      expg = (e == 0) ? g0 : (e == 1) ? g1 : g2;
      if (e < gs.size()) begin
        chk({nm, "_gnt"}, 64'(gs[e]), 64'(expg));
        chk({nm, "_words"}, 64'(words[e]), 64'd16);
        chk({nm, "_idle_gap"}, 64'(gaps[e]), 64'd1);
      end else begin
        chk({nm, "_episode_missing"}, 64'(e), 64'(gs.size() + 100));
      end
    end
  endtask

  initial begin
    // T1/T2/T5 directed vectors: inputs applied in the low phase, outputs checked 1 time unit later.
    vecs.push_back(mk(1, 2'b00, 1, 16'h0000, 16'h0000, 2'b00, 2'b00, 0, 16'h0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0010, 16'h0000, 2'b00, 2'b00, 0, 16'h0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0010, 16'h0000, 2'b01, 2'b01, 0, 16'h0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0011, 16'h0000, 2'b01, 2'b01, 1, 16'h0010, D0, W0));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0012, 16'h0000, 2'b01, 2'b01, 1, 16'h0011, D0, W0));
    vecs.push_back(mk(0, 2'b00, 1, 16'h0012, 16'h0000, 2'b01, 2'b01, 1, 16'h0012, D0, W0));
    vecs.push_back(mk(0, 2'b00, 1, 16'h0012, 16'h0000, 2'b00, 2'b00, 0, 16'h0012, D0, W0));
    vecs.push_back(mk(0, 2'b10, 0, 16'h0000, 16'h0200, 2'b00, 2'b00, 0, 16'h0012, D0, W0));
    vecs.push_back(mk(0, 2'b10, 0, 16'h0000, 16'h0200, 2'b10, 2'b10, 0, 16'h0012, D0, W0));
    vecs.push_back(mk(0, 2'b10, 0, 16'h0000, 16'h0201, 2'b10, 2'b00, 1, 16'h0200, D1, W1));
    vecs.push_back(mk(1, 2'b10, 0, 16'h0000, 16'h0201, 2'b00, 2'b00, 0, 16'h0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 2'b11, 1, 16'h0030, 16'h0300, 2'b00, 2'b00, 0, 16'h0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 2'b11, 1, 16'h0030, 16'h0300, 2'b01, 2'b01, 0, 16'h0000, 32'h0, 4'h0));
    vecs.push_back(mk(0, 2'b10, 1, 16'h0030, 16'h0300, 2'b01, 2'b01, 1, 16'h0030, D0, W0));
    vecs.push_back(mk(0, 2'b10, 1, 16'h0030, 16'h0300, 2'b00, 2'b00, 0, 16'h0030, D0, W0));
    vecs.push_back(mk(0, 2'b11, 1, 16'h0040, 16'h0300, 2'b10, 2'b10, 0, 16'h0030, D0, W0));
    vecs.push_back(mk(0, 2'b11, 1, 16'h0040, 16'h0301, 2'b10, 2'b10, 1, 16'h0300, D1, W1));
    vecs.push_back(mk(0, 2'b11, 1, 16'h0040, 16'h0302, 2'b10, 2'b10, 1, 16'h0301, D1, W1));
    vecs.push_back(mk(0, 2'b11, 1, 16'h0040, 16'h0303, 2'b10, 2'b10, 1, 16'h0302, D1, W1));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0040, 16'h0303, 2'b10, 2'b10, 1, 16'h0303, D1, W1));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0040, 16'h0303, 2'b00, 2'b00, 0, 16'h0303, D1, W1));
    vecs.push_back(mk(0, 2'b01, 1, 16'h0040, 16'h0303, 2'b01, 2'b01, 0, 16'h0303, D1, W1));
    vecs.push_back(mk(0, 2'b00, 1, 16'h0040, 16'h0303, 2'b01, 2'b01, 1, 16'h0040, D0, W0));
    vecs.push_back(mk(0, 2'b00, 1, 16'h0040, 16'h0303, 2'b00, 2'b00, 0, 16'h0040, D0, W0));

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      rst      = vecs[k].rst;
      req_rts  = vecs[k].rts;
      mem_rtr  = vecs[k].mrtr;
      req_addr = {vecs[k].a1, vecs[k].a0};
      req_data = {D1, D0};
      req_wben = {W1, W0};
      #1;
      chk($sformatf("v%0d_gnt", k), 64'(arb_gnt), 64'(vecs[k].egnt));
      chk($sformatf("v%0d_rtr", k), 64'(req_rtr), 64'(vecs[k].ertr));
      chk($sformatf("v%0d_mem_rts", k), 64'(mem_rts), 64'(vecs[k].emrts));
      chk($sformatf("v%0d_mem_word", k), {mem_addr, mem_data, mem_wben},
          {vecs[k].ema, vecs[k].emd, vecs[k].emw});
    end

    // T3: both requesters busy, three full bursts.
    do_reset();
    m_rts = 2'b11;
    m_mrtr = 1'b1;
    repeat (60) cycle();
`ifdef FBA_FIXED_PRIO_EN
    check_episodes("t3", 3, 2'b01, 2'b01, 2'b01);
    // T6: req1 gets the port only once req0 stops asking.
    m_rts = 2'b10;
    repeat (4) cycle();
    chk("t6_req1_granted", 64'(arb_gnt), 64'(2'b10));
`else
    check_episodes("t3", 3, 2'b01, 2'b10, 2'b01);
`endif
    drain();

    // T4: five stalled cycles mid-burst from a sole requester.
    do_reset();
    m_rts = 2'b01;
    m_mrtr = 1'b1;
    repeat (6) cycle();
    m_mrtr = 1'b0;
    repeat (5) cycle();
    m_mrtr = 1'b1;
    repeat (30) cycle();
    check_episodes("t4", 2, 2'b01, 2'b01, 2'b01);
    drain();
    chk("t4_words_sent", 64'(cnt[0]), 64'(cnt[0] >= 32 ? cnt[0] : 32));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
